// File: rtl/spi_bus_regs.sv
// spi_bus_regs: register bank on the SPI controller's parallel bus.
// Writes are synchronized into clk and committed on the synchronized
// falling edge of write_n. Reads are served combinationally onto data_bus.
module spi_bus_regs #(
    parameter logic [7:0]  ID_VALUE  = 8'hA5,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] address_bus,
    inout  logic [7:0] data_bus,
    input  logic       read_n,
    input  logic       write_n,
    input  logic [7:0] switches,
    output logic [7:0] leds
);

    logic                 wr_s1, wr_s2, wr_s3;
    logic [1:0]           sync_live;
    logic                 rd_s1, rd_s2;
    logic [7:0]           sw_s1, sw_s2;
    logic [7:0]           scratch;
    logic [7:0]           wcount;
    logic                 ctrl_en;
    logic                 wr_pend;
    logic [CNT_WIDTH-1:0] counter;
    logic [CNT_WIDTH-1:0] snapshot;
    logic                 commit;
    logic                 wr_led, wr_scr, wr_ctrl, counted;
    logic                 do_clear, do_snap;
    logic [7:0]           rdata;
    logic                 rd_oe;

    // Synchronize the strobes and switches into clk. The edge-detect flop
    // only follows wr_s2 once wr_s2 holds a real post-reset sample, so a
    // write_n already low at reset release never looks like a 1->0 edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_s1     <= 1'b1;
            wr_s2     <= 1'b1;
            wr_s3     <= 1'b0;
            sync_live <= '0;
            rd_s1     <= 1'b1;
            rd_s2     <= 1'b1;
            sw_s1     <= '0;
            sw_s2     <= '0;
        end else begin
            wr_s1     <= write_n;
            wr_s2     <= wr_s1;
            sync_live <= {sync_live[0], 1'b1};
            wr_s3     <= sync_live[1] ? wr_s2 : 1'b0;
            rd_s1     <= read_n;
            rd_s2     <= rd_s1;
            sw_s1     <= switches;
            sw_s2     <= sw_s1;
        end
    end

    // Decode a single write commit per synchronized falling edge
    always_comb begin
        commit   = wr_s3 & ~wr_s2 & rd_s2;
        wr_led   = commit && (address_bus == 7'h01);
        wr_scr   = commit && (address_bus == 7'h03);
        wr_ctrl  = commit && (address_bus == 7'h06);
        counted  = wr_led | wr_scr | wr_ctrl;
        do_clear = wr_ctrl & data_bus[1];
        do_snap  = wr_ctrl & data_bus[2];
    end

    // Writable registers and the write counter (one cycle behind the commit)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            leds    <= '0;
            scratch <= '0;
            ctrl_en <= 1'b0;
            wr_pend <= 1'b0;
            wcount  <= '0;
        end else begin
            if (wr_led)  leds    <= data_bus;
            if (wr_scr)  scratch <= data_bus;
            if (wr_ctrl) ctrl_en <= data_bus[0];
            wr_pend <= counted;
            if (wr_pend) wcount <= wcount + 8'd1;
        end
    end

    // Free-running counter with clear priority and pre-update snapshot
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            counter  <= '0;
            snapshot <= '0;
        end else begin
            if (do_snap) snapshot <= counter;
            if (do_clear)     counter <= '0;
            else if (ctrl_en) counter <= counter + CNT_WIDTH'(1);
        end
    end

    // Combinational read mux
    always_comb begin
        rd_oe = ~read_n & write_n;
        case (address_bus)
            7'h00:   rdata = ID_VALUE;
            7'h01:   rdata = leds;
            7'h02:   rdata = sw_s2;
            7'h03:   rdata = scratch;
            7'h04:   rdata = snapshot[7:0];
            7'h05:   rdata = snapshot[15:8];
            7'h06:   rdata = {7'd0, ctrl_en};
            7'h07:   rdata = wcount;
            default: rdata = '0;
        endcase
    end

    assign data_bus = rd_oe ? rdata : 'z;

endmodule

// File: tb/tb_spi_bus_regs.sv
// Testbench for spi_bus_regs: directed scenarios plus randomized
// write/read traffic checked against a register-map model.
module tb_spi_bus_regs;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] address_bus;
    wire  [7:0] data_bus;
    logic       read_n, write_n;
    logic [7:0] switches;
    logic [7:0] leds;
    logic [7:0] tb_data;
    logic       tb_oe;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model of the register map
    logic [7:0] m_leds, m_scratch, m_sw, m_wcount;
    logic       m_en;

    assign data_bus = tb_oe ? tb_data : 'z;

    always #5 clk = ~clk;

    spi_bus_regs #(.ID_VALUE(8'hA5), .CNT_WIDTH(16)) dut (
        .clk(clk),
        .reset(reset),
        .address_bus(address_bus),
        .data_bus(data_bus),
        .read_n(read_n),
        .write_n(write_n),
        .switches(switches),
        .leds(leds)
    );

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_leds = 8'h00; m_scratch = 8'h00; m_wcount = 8'h00; m_en = 1'b0; m_sw = 8'h00;
    endfunction

    function automatic void model_write(input logic [6:0] a, input logic [7:0] d);
        if (a == 7'h01) m_leds = d;
        if (a == 7'h03) m_scratch = d;
        if (a == 7'h06) m_en = d[0];
        if (a == 7'h01 || a == 7'h03 || a == 7'h06) m_wcount = m_wcount + 8'd1;
    endfunction

    function automatic logic [7:0] model_read(input logic [6:0] a);
        case (a)
            7'h00: return 8'hA5;
            7'h01: return m_leds;
            7'h02: return m_sw;
            7'h03: return m_scratch;
            7'h06: return {7'd0, m_en};
            7'h07: return m_wcount;
            default: return 8'h00;
        endcase
    endfunction

    task automatic bus_write(input logic [6:0] a, input logic [7:0] d);
        @(negedge clk);
        address_bus = a; tb_data = d; tb_oe = 1'b1; write_n = 1'b0;
        repeat (6) @(negedge clk);
        write_n = 1'b1;
        repeat (3) @(negedge clk);
        tb_oe = 1'b0;
        model_write(a, d);
    endtask

    task automatic bus_read(input logic [6:0] a, output logic [7:0] d);
        @(negedge clk);
        address_bus = a; tb_oe = 1'b0; read_n = 1'b0;
        #2 d = data_bus;
        read_n = 1'b1;
    endtask

    task automatic read_check(input string tag, input logic [6:0] a);
        logic [7:0] d;
        bus_read(a, d);
        check_eq(tag, {8'd0, d}, {8'd0, model_read(a)});
    endtask

    // With the bench driving 0x00, any DUT drive of a nonzero value shows up
    task automatic z_check(input string tag);
        tb_oe = 1'b1; tb_data = 8'h00;
        #1 check_eq(tag, {8'd0, data_bus}, 16'h0000);
        tb_oe = 1'b0;
    endtask

    task automatic read_snap(output logic [15:0] s);
        logic [7:0] lo, hi;
        bus_read(7'h04, lo);
        bus_read(7'h05, hi);
        s = {hi, lo};
    endtask

    initial begin
        logic [15:0] snap;
        logic [7:0]  d, prev_wc;
        logic [6:0]  a;

        reset = 1'b1; read_n = 1'b1; write_n = 1'b1; address_bus = '0;
        switches = 8'h00; tb_oe = 1'b0; tb_data = 8'h00;
        model_reset();
        repeat (3) @(negedge clk);
        read_check("rst_read_id", 7'h00);
        read_check("rst_read_led", 7'h01);
        check_eq("rst_leds", {8'd0, leds}, 16'h0000);
        reset = 1'b0;

        // Post-reset reads and idle bus
        read_check("read_id", 7'h00);
        read_check("read_led0", 7'h01);
        read_check("read_wcount0", 7'h07);
        address_bus = 7'h00;
        z_check("idle_hiz");

        // LED write with latency window
        @(negedge clk);
        address_bus = 7'h01; tb_data = 8'h3C; tb_oe = 1'b1; write_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 check_eq("led_early", {8'd0, leds}, 16'h0000);
        repeat (2) @(posedge clk);
        #1 check_eq("led_late", {8'd0, leds}, 16'h003C);
        repeat (3) @(negedge clk);
        write_n = 1'b1;
        repeat (3) @(negedge clk);
        tb_oe = 1'b0;
        model_write(7'h01, 8'h3C);
        read_check("read_led", 7'h01);
        read_check("wcount1", 7'h07);

        // Counter: enable, run, then clear+snapshot
        bus_write(7'h06, 8'h01);
        repeat (100) @(negedge clk);
        bus_write(7'h06, 8'h07);
        read_snap(snap);
        check_eq("snap_range", {15'd0, (snap >= 16'd100 && snap <= 16'd115)}, 16'h0001);
        if (!(snap >= 16'd100 && snap <= 16'd115)) $display("snapshot value %0d", snap);
        read_check("ctrl_reads_en", 7'h06);
        bus_write(7'h06, 8'h05);
        read_snap(snap);
        check_eq("restart_range", {15'd0, (snap >= 16'd5 && snap <= 16'd16)}, 16'h0001);

        // Counter wrap: clear+enable, run past 0xFFFF, snapshot
        bus_write(7'h06, 8'h03);
        repeat (65532) @(posedge clk);
        bus_write(7'h06, 8'h05);
        read_snap(snap);
        check_eq("wrap_range", {15'd0, (snap <= 16'd8)}, 16'h0001);
        if (snap > 16'd8) $display("wrap snapshot value %0d", snap);
        bus_write(7'h06, 8'h00);

        // Read-only / unmapped writes and strobe overlap
        bus_write(7'h00, 8'h11);
        bus_write(7'h50, 8'h22);
        read_check("ro_id", 7'h00);
        read_check("unmapped", 7'h50);
        @(negedge clk);
        address_bus = 7'h00; tb_data = 8'h00; tb_oe = 1'b1; read_n = 1'b0; write_n = 1'b0;
        #2 check_eq("overlap_hiz", {8'd0, data_bus}, 16'h0000);
        repeat (6) @(negedge clk);
        read_n = 1'b1; write_n = 1'b1;
        address_bus = 7'h03; tb_data = 8'h5A; read_n = 1'b0; write_n = 1'b0;
        repeat (6) @(negedge clk);
        read_n = 1'b1; write_n = 1'b1;
        repeat (3) @(negedge clk);
        tb_oe = 1'b0;
        read_check("overlap_scratch", 7'h03);
        read_check("overlap_wcount", 7'h07);

        // Reset during a pending write, released with write_n still low
        @(negedge clk);
        address_bus = 7'h01; tb_data = 8'h77; tb_oe = 1'b1; write_n = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        write_n = 1'b1;
        repeat (3) @(negedge clk);
        tb_oe = 1'b0;
        check_eq("rstmid_leds", {8'd0, leds}, 16'h0000);
        read_check("rstmid_wcount", 7'h07);
        bus_write(7'h01, 8'h81);
        check_eq("after_rst_leds", {8'd0, leds}, {8'd0, m_leds});
        read_check("after_rst_wcount", 7'h07);

        // 256 scratch writes wrap the write count
        bus_read(7'h07, prev_wc);
        for (int i = 0; i < 256; i++) bus_write(7'h03, 8'($urandom));
        read_check("wrap_scratch", 7'h03);
        bus_read(7'h07, d);
        check_eq("wcount_wrap", {8'd0, d}, {8'd0, prev_wc});

        // Randomized traffic
        for (int i = 0; i < 80; i++) begin
            switches = 8'($urandom);
            repeat (3) @(negedge clk);
            m_sw = switches;
            a = ($urandom_range(0, 1) == 0) ? 7'($urandom_range(0, 7)) : 7'($urandom);
            if (a == 7'h06) d = 8'($urandom) & 8'hF9;
            else d = 8'($urandom);
            bus_write(a, d);
            a = 7'($urandom_range(0, 9));
            if (a == 7'h04 || a == 7'h05) a = 7'h02;
            if (a >= 7'h08) a = 7'($urandom_range(8, 127));
            read_check("rand_read", a);
            check_eq("rand_leds", {8'd0, leds}, {8'd0, m_leds});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
